// File: rtl/ct_f_spsram_req_ctrl.sv
// ct_f_spsram_req_ctrl
//   Request-side controller for one single-port SRAM macro. Converts a
//   valid/ready read/write request stream into SRAM pin activity and returns
//   read data (1-cycle SRAM latency) through an in-order response FIFO with
//   valid/ready backpressure.
//
//   Optional feature macro: CT_SPSRAM_CTRL_INIT_EN
//     defined   : after reset every address is written with zero, one per
//                 cycle, before requests are accepted.
//     undefined : requests are accepted from the first cycle out of reset.
//
// Ports
//   CLK, RST                 clock (shared with SRAM), sync active-high reset
//   req_vld/req_rdy          request handshake
//   req_wr/req_addr          request type (1=write) and address
//   req_wdata/req_wmask      write data and per-bit write enable (active-high)
//   rsp_vld/rsp_rdy          read response handshake
//   rsp_rdata                read data, in request order
//   init_done                controller accepting requests
//   A/CEN/GWEN/WEN/D         SRAM pins (CEN/GWEN/WEN active-low)
//   Q                        SRAM read data, valid the cycle after a read
module ct_f_spsram_req_ctrl #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 144,
  parameter int unsigned RSP_DEPTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

  logic                  run_c;
  logic                  init_c;
  logic [ADDR_WIDTH-1:0] init_addr_c;

  // Initialisation sequencer (or constant RUN when the feature is disabled)
`ifdef CT_SPSRAM_CTRL_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;
  localparam logic [ADDR_WIDTH-1:0] INIT_LAST = '1;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] init_addr_q;
  logic                  init_done_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
    end else if (state_q == ST_INIT) begin
      init_addr_q <= init_addr_q + ADDR_WIDTH'(1);
      if (init_addr_q == INIT_LAST) begin
        state_q     <= ST_RUN;
        init_done_q <= 1'b1;
      end
    end
  end

  assign run_c       = (state_q == ST_RUN);
  assign init_c      = (state_q == ST_INIT) & ~RST;
  assign init_addr_c = init_addr_q;
`else
  logic init_done_q;

  always_ff @(posedge CLK) begin
    if (RST) init_done_q <= 1'b1;
  end

  assign run_c       = 1'b1;
  assign init_c      = 1'b0;
  assign init_addr_c = '0;
`endif

  assign init_done = init_done_q;

  logic                  acc_c, rd_acc_c, pop_c, push_c;
  logic [CNT_W-1:0]      cnt_q, cnt_d, fifo_cnt_c;
  logic                  rd_pend_q;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic                  rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  // Writes are never blocked; reads need a free response credit
  assign req_rdy  = run_c & ~RST & (req_wr | (cnt_q < CNT_MAX));
  assign acc_c    = req_vld & req_rdy;
  assign rd_acc_c = acc_c & ~req_wr;

  // SRAM pin drive
  always_comb begin
    A    = req_addr;
    D    = req_wdata;
    CEN  = 1'b1;
    GWEN = 1'b1;
    WEN  = '1;
    if (init_c) begin
      A    = init_addr_c;
      D    = '0;
      CEN  = 1'b0;
      GWEN = 1'b0;
      WEN  = '0;
    end else if (acc_c) begin
      CEN = 1'b0;
      if (req_wr) begin
        GWEN = 1'b0;
        WEN  = ~req_wmask;
      end
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign push_c     = rd_pend_q;
  assign pop_c      = rsp_vld_q & rsp_rdy;
  // Credits cover the read in the SRAM plus the buffered entries
  assign fifo_cnt_c = cnt_q - CNT_W'(rd_pend_q);

  // Response FIFO next state; rsp_rdata always mirrors the current head
  always_comb begin
    cnt_d       = cnt_q + CNT_W'(rd_acc_c) - CNT_W'(pop_c);
    rd_ptr_d    = pop_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d    = push_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rsp_vld_d   = (fifo_cnt_c + CNT_W'(push_c) - CNT_W'(pop_c)) != '0;
    rsp_rdata_d = rsp_rdata_q;
    if (push_c && (fifo_cnt_c == CNT_W'(pop_c))) begin
      // FIFO is (or is becoming) empty: incoming Q is the new head
      rsp_rdata_d = Q;
    end else if (pop_c && (fifo_cnt_c > CNT_W'(1))) begin
      rsp_rdata_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q       <= '0;
      rd_pend_q   <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      rd_pend_q   <= rd_acc_c;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Response storage, captured from Q the cycle after a read access
  always_ff @(posedge CLK) begin
    if (push_c && !RST) mem_q[wr_ptr_q] <= Q;
  end

  assign rsp_vld   = rsp_vld_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ct_f_spsram_req_ctrl.sv
// Bench for ct_f_spsram_req_ctrl: behavioural SRAM on the pin side, a
// reference memory plus response scoreboard, and directed scenarios.
module tb_ct_f_spsram_req_ctrl;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 144;
  localparam int unsigned DEPTH = 3;
  localparam int BOUND = 300;

  logic          CLK;
  logic          RST;
  logic          req_vld, req_rdy, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, req_wmask;
  logic          rsp_vld, rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic [AW-1:0] A;
  logic          CEN, GWEN;
  logic [DW-1:0] WEN, D, Q;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] sram    [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] exp_q   [$];

  ct_f_spsram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural single-port SRAM, 1-cycle read latency, active-low bit write enable
  always @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) sram[A] <= (sram[A] & WEN) | (D & ~WEN);
      else       Q <= sram[A];
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {9{b, b ^ 8'h5A}};
  endfunction

  // Scoreboard: expected read data pushed at accept, compared at response pop
  always @(negedge CLK) begin
    if (req_vld && req_rdy) begin
      if (req_wr) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
      else        exp_q.push_back(ref_mem[req_addr]);
    end
    if (rsp_vld && rsp_rdy) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL rsp_unexpected observed=%h expected=none", rsp_rdata);
      end
      if (exp_q.size() != 0) check("rsp_data", rsp_rdata, exp_q.pop_front());
    end
  end

  task automatic issue(input logic wr, input int addr, input logic [DW-1:0] wd, input logic [DW-1:0] wm);
    int k;
    req_vld = 1'b1; req_wr = wr; req_addr = AW'(addr); req_wdata = wd; req_wmask = wm;
    k = 0;
    @(negedge CLK);
    while (!req_rdy && k < BOUND) begin
      @(negedge CLK);
      k++;
    end
    check("issue_rdy", req_rdy, 1);
    @(posedge CLK); #1;
    req_vld = 1'b0;
  endtask

  task automatic burst_reads(input int start, input int ncyc, output int nacc);
    logic acc;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = AW'(start); nacc = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge CLK);
      acc = req_rdy;
      if (acc) nacc++;
      if (rsp_vld && !rsp_rdy && exp_q.size() != 0) check("rsp_hold", rsp_rdata, exp_q[0]);
      @(posedge CLK); #1;
      if (acc) req_addr = req_addr + AW'(1);
    end
    req_vld = 1'b0;
  endtask

  task automatic drain();
    rsp_rdy = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge CLK);
      if (exp_q.size() == 0) break;
    end
    check("drain_empty", 144'(exp_q.size()), 0);
    @(posedge CLK); #1;
  endtask

  task automatic wait_init();
    for (int k = 0; k < BOUND; k++) begin
      @(negedge CLK);
      if (init_done) break;
    end
    check("init_done", init_done, 1);
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc, nresp, ngood;
    RST = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_rdy = 1'b1;
    repeat (3) @(posedge CLK);

    // Reset state
    @(negedge CLK);
    check("rst_req_rdy", req_rdy, 0);
    check("rst_cen", CEN, 1);
    check("rst_gwen", GWEN, 1);
    check("rst_wen", WEN, {DW{1'b1}});
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
`ifdef CT_SPSRAM_CTRL_INIT_EN
    check("rst_init_done", init_done, 0);
`else
    check("rst_init_done", init_done, 1);
`endif
    @(posedge CLK); #1;
    RST = 1'b0;

`ifdef CT_SPSRAM_CTRL_INIT_EN
    // T6: zero-fill sequence
    ngood = 0;
    for (int k = 0; k < 128; k++) begin
      @(negedge CLK);
      if (!CEN && !GWEN && WEN == '0 && D == '0 && A == AW'(k) && !req_rdy && !init_done) ngood++;
      @(posedge CLK); #1;
    end
    check("t6_init_cycles", 144'(ngood), 128);
    @(negedge CLK);
    check("t6_init_done", init_done, 1);
    check("t6_req_rdy", req_rdy, 1);
    @(posedge CLK); #1;
    for (int a = 0; a < 2**AW; a++) ref_mem[a] = '0;
    issue(1'b0, 9, '0, '0);
    @(negedge CLK);
    @(negedge CLK);
    check("t6_read_zero", rsp_rdata, 0);
    @(posedge CLK); #1;
    drain();
`endif

    // Preload every address with back-to-back writes
    for (int a = 0; a < 2**AW; a++) issue(1'b1, a, pat(a), {DW{1'b1}});

    // T1: write then read, pin activity and 2-cycle latency
    req_vld = 1'b1; req_wr = 1'b1; req_addr = AW'(5);
    req_wdata = {18{8'hA5}}; req_wmask = {DW{1'b1}};
    @(negedge CLK);
    check("t1_wr_rdy", req_rdy, 1);
    check("t1_wr_cen", CEN, 0);
    check("t1_wr_gwen", GWEN, 0);
    check("t1_wr_wen", WEN, 0);
    check("t1_wr_a", A, 5);
    check("t1_wr_d", D, {18{8'hA5}});
    @(posedge CLK); #1;
    req_vld = 1'b0;
    @(negedge CLK);
    check("t1_idle_cen", CEN, 1);
    @(posedge CLK); #1;
    issue(1'b0, 5, '0, '0);
    @(negedge CLK);
    check("t1_vld_n1", rsp_vld, 0);
    @(negedge CLK);
    check("t1_vld_n2", rsp_vld, 1);
    check("t1_rdata", rsp_rdata, {18{8'hA5}});
    @(posedge CLK); #1;
    drain();

    // T2: partial write over zero
    issue(1'b1, 10, '0, {DW{1'b1}});
    issue(1'b1, 10, {DW{1'b1}}, 144'h0F);
    issue(1'b0, 10, '0, '0);
    @(negedge CLK);
    @(negedge CLK);
    check("t2_vld", rsp_vld, 1);
    check("t2_rdata", rsp_rdata, 144'h0F);
    @(posedge CLK); #1;
    drain();

    // T3: backpressure, credits stop reads but not writes
    rsp_rdy = 1'b0;
    burst_reads(1, 6, nacc);
    check("t3_accepted", 144'(nacc), DEPTH);
    req_wr = 1'b0;
    @(negedge CLK);
    check("t3_rd_blocked", req_rdy, 0);
    check("t3_rsp_vld", rsp_vld, 1);
    check("t3_head", rsp_rdata, pat(1));
    @(posedge CLK); #1;
    req_wr = 1'b1;
    @(negedge CLK);
    check("t3_wr_allowed", req_rdy, 1);
    @(posedge CLK); #1;
    rsp_rdy = 1'b1;
    issue(1'b0, 4, '0, '0);
    issue(1'b0, 5, '0, '0);
    drain();

    // T4: sustained one read per cycle
    nresp = 0;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = AW'(20);
    for (int c = 0; c < 18; c++) begin
      @(negedge CLK);
      if (c < 16) check("t4_rdy", req_rdy, 1);
      if (c >= 2 && rsp_vld) nresp++;
      @(posedge CLK); #1;
      if (c < 15) req_addr = AW'(21 + c);
      else        req_vld = 1'b0;
    end
    check("t4_resp_count", 144'(nresp), 16);
    drain();

    // T5: reset with a response pending and a read in flight
    rsp_rdy = 1'b0;
    issue(1'b0, 6, '0, '0);
    issue(1'b0, 7, '0, '0);
    RST = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    check("t5_pre_vld", rsp_vld, 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("t5_rst_vld", rsp_vld, 0);
    check("t5_rst_rdy", req_rdy, 0);
    check("t5_rst_cen", CEN, 1);
    @(posedge CLK); #1;
    RST = 1'b0;
    wait_init();
`ifdef CT_SPSRAM_CTRL_INIT_EN
    for (int a = 0; a < 2**AW; a++) ref_mem[a] = '0;
`endif
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      check("t5_no_stale", rsp_vld, 0);
      @(posedge CLK); #1;
    end
    burst_reads(30, 6, nacc);
    check("t5_credits", 144'(nacc), DEPTH);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
